// File: rtl/cv32e40p_tmr_vote_monitor.sv
// rtl/cv32e40p_tmr_vote_monitor.sv - TMR voter with per-replica error counters and TMR/DMR/SIMPLEX degradation
// Optional macro CV32E40P_TMR_VOTE_OUT_REG_EN registers the vote and error outputs.
module cv32e40p_tmr_vote_monitor #(
  parameter int NSIG      = 3,
  parameter int WIDTH     = 1,
  parameter int INCREMENT = 4,
  parameter int DECREMENT = 1,
  parameter int THRESHOLD = 16,
  parameter int COUNT_BIT = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [3*NSIG*WIDTH-1:0]   to_vote_i,
  output logic [NSIG*WIDTH-1:0]     voted_o,
  input  logic [2:0]                set_broken_i,
  input  logic [2:0]                clr_broken_i,
  output logic [2:0]                is_broken_o,
  output logic [2:0]                block_err_o,
  output logic                      err_detected_o,
  output logic                      err_corrected_o,
  output logic [1:0]                mode_o
);

  localparam int N = NSIG * WIDTH;
  localparam logic [COUNT_BIT:0] CMAX = {1'b0, {COUNT_BIT{1'b1}}};
  localparam logic [COUNT_BIT:0] INC  = (COUNT_BIT+1)'(INCREMENT);
  localparam logic [COUNT_BIT:0] DEC  = (COUNT_BIT+1)'(DECREMENT);
  localparam logic [COUNT_BIT:0] THR  = (COUNT_BIT+1)'(THRESHOLD);

  typedef enum logic [1:0] {HEALTHY, SUSPECT, BROKEN} health_e;

  logic [N-1:0] rep0, rep1, rep2, maj;
  logic [N-1:0] voted_c;
  logic [2:0]   blk_c;
  logic         det_c, cor_c;

  assign rep0 = to_vote_i[0*N +: N];
  assign rep1 = to_vote_i[1*N +: N];
  assign rep2 = to_vote_i[2*N +: N];
  assign maj  = (rep0 & rep1) | (rep0 & rep2) | (rep1 & rep2);

  // Vote selection depends only on the registered broken flags.
  always_comb begin
    voted_c = rep0;
    blk_c   = 3'b000;
    det_c   = 1'b0;
    cor_c   = 1'b0;
    case (is_broken_o)
      3'b000: begin
        voted_c = maj;
        blk_c   = {|(rep2 ^ maj), |(rep1 ^ maj), |(rep0 ^ maj)};
        det_c   = |blk_c;
        cor_c   = |blk_c;
      end
      3'b001: begin
        voted_c = rep1;
        det_c   = (rep1 != rep2);
        blk_c   = {det_c, det_c, 1'b0};
      end
      3'b010: begin
        voted_c = rep0;
        det_c   = (rep0 != rep2);
        blk_c   = {det_c, 1'b0, det_c};
      end
      3'b100: begin
        voted_c = rep0;
        det_c   = (rep0 != rep1);
        blk_c   = {1'b0, det_c, det_c};
      end
      3'b011:  voted_c = rep2;
      3'b101:  voted_c = rep1;
      3'b110:  voted_c = rep0;
      default: det_c   = 1'b1;
    endcase
  end

  always_comb begin
    case (is_broken_o)
      3'b000:                 mode_o = 2'd0;
      3'b001, 3'b010, 3'b100: mode_o = 2'd1;
      3'b111:                 mode_o = 2'd3;
      default:                mode_o = 2'd2;
    endcase
  end

  for (genvar r = 0; r < 3; r++) begin : g_rep
    health_e                state_q;
    logic [COUNT_BIT-1:0]   count_q;
    logic [COUNT_BIT:0]     ext, cnt_wide;
    logic [COUNT_BIT-1:0]   cnt_next;

    assign ext      = {1'b0, count_q};
    assign cnt_wide = blk_c[r] ? ext + INC : ext - DEC;
    always_comb begin
      cnt_next = cnt_wide[COUNT_BIT-1:0];
      if (blk_c[r] && cnt_wide > CMAX) cnt_next = {COUNT_BIT{1'b1}};
      if (!blk_c[r] && ext < DEC)      cnt_next = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= HEALTHY;
        count_q <= '0;
      end else if (state_q == BROKEN) begin
        // set wins over clr; the counter stays frozen while broken
        if (clr_broken_i[r] && !set_broken_i[r]) begin
          state_q <= HEALTHY;
          count_q <= '0;
        end
      end else begin
        count_q <= cnt_next;
        if (set_broken_i[r] || {1'b0, cnt_next} >= THR) state_q <= BROKEN;
        else if (cnt_next != '0)                        state_q <= SUSPECT;
        else                                            state_q <= HEALTHY;
      end
    end

    assign is_broken_o[r] = (state_q == BROKEN);
  end

`ifdef CV32E40P_TMR_VOTE_OUT_REG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      voted_o         <= '0;
      block_err_o     <= '0;
      err_detected_o  <= 1'b0;
      err_corrected_o <= 1'b0;
    end else begin
      voted_o         <= voted_c;
      block_err_o     <= blk_c;
      err_detected_o  <= det_c;
      err_corrected_o <= cor_c;
    end
  end
`else
  assign voted_o         = voted_c;
  assign block_err_o     = blk_c;
  assign err_detected_o  = det_c;
  assign err_corrected_o = cor_c;
`endif

endmodule

// File: doc/cv32e40p_tmr_vote_monitor.md
Name: cv32e40p_tmr_vote_monitor

Overview:
- Generic triple-modular-redundancy (TMR) vote-and-health block for the fault-tolerant cv32e40p wrappers.
- Votes NSIG independent output signals of WIDTH bits each from three replicas.
- Tracks per-replica error history with saturating counters and a per-replica health FSM.
- Degrades automatically TMR -> DMR -> SIMPLEX as replicas break, replacing the fixed 1-bit voters plus separate breakage monitors in each *_ft wrapper.

Parameters:
- NSIG, 3, number of voted signals.
- WIDTH, 1, bits per signal.
- INCREMENT, 4, counter step on a replica error cycle.
- DECREMENT, 1, counter step on a clean cycle.
- THRESHOLD, 16, count at or above which a replica is declared broken.
- COUNT_BIT, 5, counter width; requires THRESHOLD <= 2^COUNT_BIT-1.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- to_vote_i, input, 3*NSIG*WIDTH, replica r occupies slice [r*NSIG*WIDTH +: NSIG*WIDTH].
- voted_o, output, NSIG*WIDTH, voted result.
- set_broken_i, input, 3, force replica broken.
- clr_broken_i, input, 3, restore replica to healthy.
- is_broken_o, output, 3, registered broken flags.
- block_err_o, output, 3, replica r disagrees with the vote this cycle.
- err_detected_o, output, 1, any mismatch among the replicas in use.
- err_corrected_o, output, 1, mismatch masked by the majority vote.
- mode_o, output, 2, 0=TMR, 1=DMR, 2=SIMPLEX, 3=FAIL.

Behaviour:
- Reset: all counters 0, is_broken_o=0, FSMs HEALTHY, mode_o=0. The combinational outputs follow the inputs immediately.
- Voting is combinational (latency 0) and bitwise over all NSIG*WIDTH bits.
- TMR (no replica broken):
  - voted_o = bitwise majority of the three replicas.
  - block_err_o[r] = replica r differs from voted_o in any bit.
  - err_detected_o = err_corrected_o = |block_err_o.
- DMR (exactly one broken):
  - voted_o = lowest-index healthy replica.
  - err_detected_o = the two healthy replicas differ; err_corrected_o=0.
  - block_err_o[r] = err_detected_o for both healthy replicas, 0 for the broken one.
- SIMPLEX (two broken):
  - voted_o = the remaining replica.
  - err_detected_o=0, err_corrected_o=0, block_err_o=0.
- FAIL (all three broken):
  - voted_o = replica 0.
  - err_detected_o=1 every cycle, err_corrected_o=0, block_err_o=0.
- mode_o is decoded combinationally from the registered is_broken_o.
- Per-replica counter, for a non-broken replica only:
  - When block_err_o[r]=1: next = min(count+INCREMENT, 2^COUNT_BIT-1).
  - When block_err_o[r]=0: next = max(count-DECREMENT, 0).
  - Arithmetic is done in COUNT_BIT+1 bits, then saturated.
- A broken replica's counter is frozen.
- Health FSM per replica:
  - HEALTHY (count==0) -> SUSPECT when next>0.
  - SUSPECT -> HEALTHY when next==0.
  - HEALTHY/SUSPECT -> BROKEN on the same edge where next>=THRESHOLD, or when set_broken_i[r]=1.
  - BROKEN -> HEALTHY only on clr_broken_i[r]; the counter is cleared to 0 on that edge.
- is_broken_o[r] = (state==BROKEN).
- If set_broken_i[r] and clr_broken_i[r] are both asserted in the same cycle, set wins.
- A reset asserted mid-operation returns all state to the reset values asynchronously.

Optional Feature:
- Macro: CV32E40P_TMR_VOTE_OUT_REG_EN.
- When defined: voted_o, err_detected_o, err_corrected_o and block_err_o are registered.
  - Latency is 1 cycle; these outputs reset to 0.
  - Counters still update from the unregistered block errors, so broken-flag timing is unchanged.
- When undefined: these outputs are purely combinational with latency 0.

Test Plan (NSIG=2, WIDTH=8, defaults otherwise):
- All replicas drive 0x5A,0x3C -> voted_o=0x5A3C, err_detected_o=0, block_err_o=000, mode_o=0.
- Replica 1 drives 0xFF,0x3C for one cycle:
  - voted_o=0x5A3C, block_err_o=010, err_corrected_o=1.
  - Replica 1 count goes 4, then decays to 0 after 4 clean cycles (FSM back to HEALTHY).
- Replica 2 mismatches for 4 consecutive cycles -> is_broken_o=100 after the 4th edge, mode_o=1.
  - Then replica 0 != replica 1 -> voted_o = replica 0, err_detected_o=1, err_corrected_o=0.
- set_broken_i=011 pulse -> is_broken_o=011, mode_o=2, voted_o = replica 2, err_detected_o=0.
  - Then set_broken_i=100 -> mode_o=3, err_detected_o=1.
- set_broken_i=001 and clr_broken_i=001 in the same cycle -> is_broken_o[0]=1.
  - Then clr_broken_i=001 alone -> is_broken_o[0]=0, count 0, mode_o=0.
- Assert rst_n=0 mid-run with is_broken_o=110 -> is_broken_o=000 and mode_o=0 immediately, without waiting for a clock edge.
- With the macro defined, the mismatch case above shows err_corrected_o one cycle after the stimulus.
